inst_mem_sync: RTL and testbench

- Parametrised, writable successor to the combinational instruction ROM in the 5-stage pipelined CPU; feeds the IF/ID stage.
- Registered read with a 1-cycle latency, and a program-load port so test programs load at run time instead of being hard-wired.
- Pipeline stall/flush inputs support control-hazard handling (branch/jump squash).
- Detects misaligned or out-of-range fetches; clears itself to NOP after reset.

---
 rtl/inst_mem_pkg.sv | 21 ++
 rtl/inst_mem_init_seq.sv | 55 +++++
 rtl/inst_mem_sync.sv | 99 +++++++++
 tb/tb_inst_mem_sync.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared definitions for the synchronous instruction memory and its init sequencer.
// The byte-to-word helpers are also used by the data memory.
package inst_mem_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Word index of a byte address; callers keep the low ADDR_W bits and range-check the rest.
  function automatic logic [29:0] byte_to_word(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/inst_mem_init_seq.sv
// Post-reset sweep: walks every word index once so the memory starts out as NOPs,
// then parks in READY until the next reset.
module inst_mem_init_seq
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == LAST_IDX) begin
          w_next_state = ST_READY;
        end else begin
          w_next_state = ST_INIT;
        end
      end
      ST_READY: w_next_state = ST_READY;
      default:  w_next_state = ST_INIT;
    endcase
  end

  assign o_init_we   = (r_state == ST_INIT);
  assign o_init_addr = r_cnt;
  assign o_ready     = (r_state == ST_READY);

endmodule

// File: rtl/inst_mem_sync.sv
// Writable instruction memory for the IF/ID stage: registered 1-cycle read with
// stall/flush control, address error flag, and a run-time program-load port.
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_a,
  input  logic              i_fetch_en,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [DATA_W-1:0] o_inst,
  output logic              o_inst_valid,
  output logic              o_addr_err,
  output logic              o_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_inst;
  logic              r_inst_valid;
  logic              r_addr_err;

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_ready;
  logic [29:0]       w_word;
  logic [ADDR_W-1:0] w_idx;
  logic              w_bad_addr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  inst_mem_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_ready     (w_ready)
  );

  assign w_word     = byte_to_word(i_a);
  assign w_idx      = w_word[ADDR_W-1:0];
  assign w_bad_addr = is_misaligned(i_a) | (|w_word[29:ADDR_W]);

  // The init sweep owns the write port until READY; a reset cycle blocks every write.
  assign w_we    = ~i_rst & (w_init_we | (w_ready & i_prog_we));
  assign w_waddr = w_init_we ? w_init_addr : i_prog_addr;
  assign w_wdata = w_init_we ? NOP_WORD : i_prog_data;

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Non-blocking update of r_mem makes a same-cycle write/fetch return the old word.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_ready) begin
      r_inst       <= NOP_WORD;
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (i_flush) begin
      r_inst       <= NOP_WORD;
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else if (i_stall) begin
      r_inst       <= r_inst;
      r_inst_valid <= r_inst_valid;
      r_addr_err   <= r_addr_err;
    end else if (i_fetch_en && w_bad_addr) begin
      r_inst       <= NOP_WORD;
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b1;
    end else if (i_fetch_en) begin
      r_inst       <= r_mem[w_idx];
      r_inst_valid <= 1'b1;
      r_addr_err   <= 1'b0;
    end else begin
      r_inst       <= r_inst;
      r_inst_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end
  end

  assign o_inst       = r_inst;
  assign o_inst_valid = r_inst_valid;
  assign o_addr_err   = r_addr_err;
  assign o_ready      = w_ready;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Scoreboard bench for inst_mem_sync: a reference model predicts each cycle's
// outputs, which are queued and compared one cycle later.
module tb_inst_mem_sync;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       a = 32'h0;
  logic              fetch_en = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [DATA_W-1:0] prog_data = '0;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              addr_err;
  logic              ready;

  inst_mem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(32'h0000_0000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_a         (a),
    .i_fetch_en  (fetch_en),
    .i_stall     (stall),
    .i_flush     (flush),
    .i_prog_we   (prog_we),
    .i_prog_addr (prog_addr),
    .i_prog_data (prog_data),
    .o_inst      (inst),
    .o_inst_valid(inst_valid),
    .o_addr_err  (addr_err),
    .o_ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic        valid;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_inst  = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  logic        m_ready = 1'b0;
  int          m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, predict outputs, push, then pop and compare after the edge.
  task automatic step(input logic rst_v, input logic fe, input logic [31:0] a_v,
                      input logic st, input logic fl, input logic pwe,
                      input logic [ADDR_W-1:0] pa, input logic [31:0] pd);
    exp_t e;
    logic [31:0] old_word;
    logic        bad;
    @(negedge clk);
    rst = rst_v; fetch_en = fe; a = a_v; stall = st; flush = fl;
    prog_we = pwe; prog_addr = pa; prog_data = pd;
    bad = (a_v[1:0] != 2'b00) || (a_v[31:ADDR_W+2] != '0);
    if (rst_v) begin
      m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_ready = 1'b0; m_cnt = 0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = 32'h0;
      m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      if (m_cnt == DEPTH - 1) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else begin
      old_word = m_mem[a_v[ADDR_W+1:2]];
      if (fl) begin
        m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      end else if (st) begin
        m_inst = m_inst;
      end else if (fe && bad) begin
        m_inst = 32'h0; m_valid = 1'b0; m_err = 1'b1;
      end else if (fe) begin
        m_inst = old_word; m_valid = 1'b1; m_err = 1'b0;
      end else begin
        m_valid = 1'b0; m_err = 1'b0;
      end
      if (pwe) m_mem[pa] = pd;
    end
    sb_q.push_back('{inst: m_inst, valid: m_valid, err: m_err, rdy: m_ready});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("sb_inst",  inst,                 e.inst);
    chk("sb_valid", {31'h0, inst_valid},  {31'h0, e.valid});
    chk("sb_err",   {31'h0, addr_err},    {31'h0, e.err});
    chk("sb_ready", {31'h0, ready},       {31'h0, e.rdy});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a_v);
    step(1'b0, 1'b1, a_v, 1'b0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic load(input logic [ADDR_W-1:0] pa, input logic [31:0] pd);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pa, pd);
  endtask

  task automatic init_and_time(input string tag);
    int first;
    first = -1;
    for (int i = 0; i < DEPTH + 6; i++) begin
      idle();
      if (ready && first < 0) first = i + 1;
    end
    chk(tag, first, DEPTH);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

    // Reset pulse and init sweep timing
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0, 32'h0);
    chk("rst_inst",  inst, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    init_and_time("init_len");

    fetch(32'h20);
    chk("init_nop", inst, 32'h0);
    chk("init_nop_valid", {31'h0, inst_valid}, 32'h1);

    // Program load and 1-cycle fetch latency
    load(6'd1, 32'h0010_0443);
    load(6'd6, 32'h4000_2828);
    fetch(32'h04);
    chk("lat_idx1", inst, 32'h0010_0443);
    fetch(32'h18);
    chk("lat_idx6", inst, 32'h4000_2828);

    // Stall holds, flush wins over stall
    fetch(32'h04);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h18, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    chk("stall_hold", inst, 32'h0010_0443);
    step(1'b0, 1'b1, 32'h18, 1'b1, 1'b1, 1'b0, '0, 32'h0);
    chk("flush_inst", inst, 32'h0);
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    idle();

    // Address errors
    fetch(32'h06);
    chk("mis_err", {31'h0, addr_err}, 32'h1);
    fetch(32'h100);
    chk("oor_err", {31'h0, addr_err}, 32'h1);
    fetch(32'hFFFF_FFFC);
    fetch(32'h04);
    chk("err_clear", {31'h0, addr_err}, 32'h0);

    // Read-first collision, writes independent of stall
    load(6'd3, 32'hAAAA_0000);
    step(1'b0, 1'b1, 32'h0C, 1'b0, 1'b0, 1'b1, 6'd3, 32'h5555_FFFF);
    chk("rf_old", inst, 32'hAAAA_0000);
    fetch(32'h0C);
    chk("rf_new", inst, 32'h5555_FFFF);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd9, 32'h1234_5678);
    fetch(32'h24);
    chk("wr_in_stall", inst, 32'h1234_5678);

    // Reset mid-run with a pending fetch and an ignored write
    fetch(32'h04);
    step(1'b1, 1'b1, 32'h04, 1'b0, 1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF);
    chk("mrst_valid", {31'h0, inst_valid}, 32'h0);
    chk("mrst_ready", {31'h0, ready}, 32'h0);
    init_and_time("reinit_len");
    fetch(32'h04);
    chk("mrst_cleared", inst, 32'h0);
    chk("mrst_cleared_v", {31'h0, inst_valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
